reg_bank: RTL
=============

Name: reg_bank

Overview:
Parametrised register bank with one write port and two independent read ports. It generalises the team's 3-to-8 decoder and 8:1 byte mux into a clocked storage block. The write path uses a one-hot address decoder. Each read path is a DEPTH:1 mux with a registered output, per-entry valid tracking and an optional write-to-read bypass. It sits between the datapath controllers and the ALU-side operand buses.

Parameters:
WIDTH, 8, data bits per entry (1..64)
DEPTH, 8, number of entries (2..64; need not be a power of two)
BYPASS, 1, 1 = same-cycle write data forwarded to a read of the same address; 0 = read returns the pre-write value
AW, $clog2(DEPTH), address width; localparam, derived, not overridable

Ports:
clk  in  1  single clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of all entries and valid bits
we  in  1  write enable
waddr  in  AW  write address
wdata  in  WIDTH  write data
re0  in  1  read enable, port 0
raddr0  in  AW  read address, port 0
rdata0  out  WIDTH  registered read data, port 0
rvalid0  out  1  registered: addressed entry was written since reset/clear
re1  in  1  read enable, port 1
raddr1  in  AW  read address, port 1
rdata1  out  WIDTH  registered read data, port 1
rvalid1  out  1  registered valid, port 1
entry_valid  out  DEPTH  bit i = entry i written since last reset/clear (registered)

Behaviour:
- Reset (rst_n low, asynchronous): all entries 0, entry_valid 0, rdata0/1 0, rvalid0/1 0. Release is synchronous to clk; the first write is accepted on the first rising edge with rst_n high.
- Write: when we=1, clr=0 and waddr<DEPTH, entry[waddr] <= wdata and entry_valid[waddr] <= 1 at the edge. Decoder output is strictly one-hot or all-zero.
- Out-of-range address (waddr>=DEPTH, only possible for non-power-of-2 DEPTH): write ignored, no state change.
- Read: latency 1. When reN=1 at edge k, rdataN/rvalidN after edge k show entry[raddrN]/entry_valid[raddrN]. When reN=0, rdataN/rvalidN hold their previous values.
- Read of an out-of-range address: rdataN <= 0, rvalidN <= 0.
- Read of a never-written entry: rdataN <= 0 (storage reset value), rvalidN <= 0.
- Same-cycle write and read of the same in-range address:
  - BYPASS=1: rdataN <= wdata, rvalidN <= 1.
  - BYPASS=0: rdataN <= old entry value, rvalidN <= old valid bit.
  - Storage is updated in both cases.
- Both read ports may address the same entry, or the write address, in the same cycle; each port resolves independently.
- clr=1: all entries <= 0 and entry_valid <= 0. clr has priority over we, so a write in the same cycle is dropped. Any read in a clr cycle returns rdataN <= 0, rvalidN <= 0, regardless of bypass.
- Reset asserted mid-operation: immediate clear of all state and outputs; no partial write survives.
- No combinational path from any input to any output.

Decomposition:
- Shared package reg_bank_pkg: RB_WIDTH_DEF=8, RB_DEPTH_DEF=8.
- Sub-module reg_bank_dec: parametrised AW-to-DEPTH one-hot decoder with enable. Out-of-range input or enable=0 gives all zeros.
- Read muxes are inline generate logic, one instance per port.

Test Plan:
1. Reset, then read all 8 addresses on both ports -> rdata=0x00, rvalid=0, entry_valid=8'h00.
2. Write 0xA5 to addr 3; next cycle re0=1 raddr0=3 -> one cycle later rdata0=0xA5, rvalid0=1, entry_valid=8'h08.
3. BYPASS=1: we=1 waddr=5 wdata=0x3C with re1=1 raddr1=5 in the same cycle -> rdata1=0x3C, rvalid1=1 after the edge. Repeat with BYPASS=0 on a fresh entry -> rdata1=0x00, rvalid1=0.
4. Fill all entries with 0x10+i; clr=1 together with we=1 waddr=2 wdata=0xFF and re0=1 raddr0=2 -> rdata0=0, rvalid0=0, entry_valid=0. A subsequent read of addr 2 returns 0/0.
5. DEPTH=6, AW=3: write 0x77 to addr 7 -> entry_valid unchanged. Read addr 6 -> rdata=0, rvalid=0.
6. re0=0 for 4 cycles while addr 3 is rewritten to 0x11 -> rdata0 holds 0xA5. Assert rst_n low mid-sequence -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared defaults for the register bank and its helpers.
package reg_bank_pkg;

  localparam int unsigned RB_WIDTH_DEF = 8;
  localparam int unsigned RB_DEPTH_DEF = 8;

  // True when an address falls inside the populated entry range.
  function automatic logic rb_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/reg_bank_dec.sv
// AW-to-DEPTH one-hot decoder with enable; out-of-range or disabled gives all zeros.
module reg_bank_dec #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             en_i,
  input  logic [AW-1:0]    addr_i,
  output logic [DEPTH-1:0] onehot_o
);

  // Compare against each populated index so codes >= DEPTH never hit a line.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (en_i && (addr_i == AW'(i))) begin
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bank.sv
// Register bank: one decoded write port, two registered read ports with valid tracking.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH  = RB_WIDTH_DEF,
  parameter int unsigned DEPTH  = RB_DEPTH_DEF,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re0,
  input  logic [AW-1:0]    raddr0,
  output logic [WIDTH-1:0] rdata0,
  output logic             rvalid0,
  input  logic             re1,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1,
  output logic             rvalid1,
  output logic [DEPTH-1:0] entry_valid
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] wr_oh;

  logic [1:0]    re;
  logic [AW-1:0] raddr [2];

  assign re       = {re1, re0};
  assign raddr[0] = raddr0;
  assign raddr[1] = raddr1;

  // clr masks the decoder so a write in a clear cycle never reaches storage.
  reg_bank_dec #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dec (
    .en_i     (we & ~clr),
    .addr_i   (waddr),
    .onehot_o (wr_oh)
  );

  // Storage next state: clear wins, otherwise the decoded entry takes wdata.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = '0;
      valid_d = '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (wr_oh[i]) begin
          mem_d[i]   = wdata;
          valid_d[i] = 1'b1;
        end
      end
    end
  end

  // Storage and valid flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      valid_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
    end
  end

  assign entry_valid = valid_q;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             in_range;

    assign in_range = rb_in_range(32'(raddr[p]), DEPTH);

    // Read mux: hold when idle; clear and out-of-range read as empty.
    always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = rvalid_q;
      if (re[p]) begin
        if (clr || !in_range) begin
          rdata_d  = '0;
          rvalid_d = 1'b0;
        end else if (BYPASS && we && (waddr == raddr[p])) begin
          rdata_d  = wdata;
          rvalid_d = 1'b1;
        end else begin
          rdata_d  = mem_q[raddr[p]];
          rvalid_d = valid_q[raddr[p]];
        end
      end
    end

    // Registered read outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    if (p == 0) begin : g_out0
      assign rdata0  = rdata_q;
      assign rvalid0 = rvalid_q;
    end else begin : g_out1
      assign rdata1  = rdata_q;
      assign rvalid1 = rvalid_q;
    end
  end

endmodule
